// File: rtl/cpu_pkg.sv
// Shared CPU constants: exception vectors, PCSrc encodings, kernel-bit index
// and the kernel-preserving PC+4 helper used by the fetch stage.
package cpu_pkg;

    localparam int          KERNEL_BIT    = 31;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;

    localparam logic [1:0]  PCSRC_SEQ     = 2'd0;
    localparam logic [1:0]  PCSRC_BRANCH  = 2'd1;
    localparam logic [1:0]  PCSRC_JUMP    = 2'd2;
    localparam logic [1:0]  PCSRC_JR      = 2'd3;

    // The increment never carries into the kernel bit, so sequential fetch
    // can neither enter nor leave kernel mode.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[KERNEL_BIT], pc[KERNEL_BIT-1:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection for the fetch stage.
// Priority: illegal opcode > accepted interrupt > stall > PCSrc.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        irq_i,
    input  logic        illop_i,
    input  logic [1:0]  pc_src_i,
    input  logic [31:0] branch_target_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] next_pc_o,
    output logic        irq_take_o,
    output logic        exc_take_o
);

    logic kernel;

    assign kernel     = pc_i[KERNEL_BIT];
    assign exc_take_o = illop_i;
    // Interrupts are level-sensitive and re-sampled every cycle; nothing is latched.
    assign irq_take_o = irq_i && !kernel && !stall_i && !illop_i;

    // NOTE: the output gets a default before any branch so no path can infer a latch.
    always_comb begin
        next_pc_o = pc_plus4(pc_i);
        if (exc_take_o) begin
            next_pc_o = EXC_VEC;
        end else if (irq_take_o) begin
            next_pc_o = IRQ_VEC;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end else begin
            case (pc_src_i)
                PCSRC_SEQ:    next_pc_o = pc_plus4(pc_i);
                PCSRC_BRANCH: next_pc_o = branch_target_i;
                PCSRC_JUMP:   next_pc_o = {pc_i[31:28], jump_index_i, 2'b00};
                PCSRC_JR:     next_pc_o = jr_target_i;
                default:      next_pc_o = pc_plus4(pc_i);
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, vectoring to IRQ/EXC handlers with EPC
// capture, and the IF/ID hand-off. Define FETCH_IFID_REG_EN to register IF/ID.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] JrTarget,
    input  logic        Irq,
    input  logic        Illop,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PC4,
    output logic        IF_Valid,
    output logic        EPC_We,
    output logic        EPC_Sel,
    output logic [31:0] EPC
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_w;
    logic        irq_take;
    logic        exc_take;
    logic        vector_take;

    assign pc_plus4_w  = pc_plus4(pc_q);
    assign vector_take = irq_take || exc_take;

    pc_next_mux #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_pc_next_mux (
        .pc_i            (pc_q),
        .stall_i         (Stall),
        .irq_i           (Irq),
        .illop_i         (Illop),
        .pc_src_i        (PCSrc),
        .branch_target_i (BranchTarget),
        .jump_index_i    (JumpIndex),
        .jr_target_i     (JrTarget),
        .next_pc_o       (pc_d),
        .irq_take_o      (irq_take),
        .exc_take_o      (exc_take)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign Address = pc_q;

`ifdef FETCH_IFID_REG_EN
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q,   if_pc4_d;
    logic        if_valid_q, if_valid_d;

    // A taken vector flushes IF/ID even under stall; a plain stall holds it.
    always_comb begin
        if_instr_d = if_instr_q;
        if_pc4_d   = if_pc4_q;
        if_valid_d = if_valid_q;
        if (vector_take) begin
            if_instr_d = '0;
            if_pc4_d   = pc_plus4_w;
            if_valid_d = 1'b0;
        end else if (!Stall) begin
            if_instr_d = Instruction;
            if_pc4_d   = pc_plus4_w;
            if_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_instr_q <= '0;
            if_pc4_q   <= '0;
            if_valid_q <= 1'b0;
        end else begin
            if_instr_q <= if_instr_d;
            if_pc4_q   <= if_pc4_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign IF_Instr = if_instr_q;
    assign IF_PC4   = if_pc4_q;
    assign IF_Valid = if_valid_q;
`else
    // Pass-through IF/ID; reset forces the idle values without waiting for clk.
    assign IF_Instr = (reset && !vector_take) ? Instruction : '0;
    assign IF_PC4   = reset ? pc_plus4_w : '0;
    assign IF_Valid = reset && !vector_take;
`endif

    assign EPC_We  = reset && vector_take;
    assign EPC_Sel = exc_take;
    assign EPC     = exc_take ? IF_PC4 : pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit (pass-through IF/ID build): a driver pushes
// expected outputs from a behavioural model, a negedge monitor pops and compares.
module tb_fetch_unit;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] EV = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic [1:0]  PCSrc = 2'd0;
    logic [31:0] BranchTarget = '0;
    logic [25:0] JumpIndex = '0;
    logic [31:0] JrTarget = '0;
    logic        Irq = 1'b0;
    logic        Illop = 1'b0;
    logic [31:0] Address;
    logic [31:0] Instruction = '0;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC4;
    logic        IF_Valid;
    logic        EPC_We;
    logic        EPC_Sel;
    logic [31:0] EPC;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .JumpIndex    (JumpIndex),
        .JrTarget     (JrTarget),
        .Irq          (Irq),
        .Illop        (Illop),
        .Address      (Address),
        .Instruction  (Instruction),
        .IF_Instr     (IF_Instr),
        .IF_PC4       (IF_PC4),
        .IF_Valid     (IF_Valid),
        .EPC_We       (EPC_We),
        .EPC_Sel      (EPC_Sel),
        .EPC          (EPC)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        we;
        logic        sel;
        logic [31:0] epc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_pc = RV;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
        end
    endtask

    function automatic logic [31:0] m_inc(input logic [31:0] pc);
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    // Apply one cycle of stimulus, predict the outputs seen during it, advance the model PC.
    task automatic drive(input logic rst, input logic st, input logic [1:0] src,
                         input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jr,
                         input logic irq, input logic ill, input logic [31:0] ins);
        exp_t e;
        logic kernel, exc, take_irq;
        @(posedge clk);
        #1;
        reset = rst; Stall = st; PCSrc = src; BranchTarget = bt; JumpIndex = ji;
        JrTarget = jr; Irq = irq; Illop = ill; Instruction = ins;
        cyc++;
        e.cyc = cyc;
        e.addr = m_pc;
        if (!rst) begin
            e.addr = RV; e.instr = '0; e.pc4 = '0; e.valid = 1'b0;
            e.we = 1'b0; e.sel = 1'b0; e.epc = '0;
            m_pc = RV;
        end else begin
            kernel   = m_pc[31];
            exc      = ill;
            take_irq = !ill && irq && !kernel && !st;
            e.pc4    = m_inc(m_pc);
            e.instr  = (exc || take_irq) ? 32'h0 : ins;
            e.valid  = !(exc || take_irq);
            e.we     = exc || take_irq;
            e.sel    = exc;
            e.epc    = exc ? e.pc4 : m_pc;
            if (exc)            m_pc = EV;
            else if (take_irq)  m_pc = IV;
            else if (st)        m_pc = m_pc;
            else if (src == 2'd1) m_pc = bt;
            else if (src == 2'd2) m_pc = (m_pc & 32'hF000_0000) | (32'(ji) * 4);
            else if (src == 2'd3) m_pc = jr;
            else                m_pc = m_inc(m_pc);
        end
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [31:0] ins);
        drive(1'b1, 1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, ins);
    endtask

    task automatic go_jr(input logic [31:0] tgt);
        drive(1'b1, 1'b0, 2'd3, '0, '0, tgt, 1'b0, 1'b0, $urandom);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("Address",  e.cyc, Address, e.addr);
                check("IF_Instr", e.cyc, IF_Instr, e.instr);
                check("IF_PC4",   e.cyc, IF_PC4, e.pc4);
                check("IF_Valid", e.cyc, {31'b0, IF_Valid}, {31'b0, e.valid});
                check("EPC_We",   e.cyc, {31'b0, EPC_We}, {31'b0, e.we});
                if (e.we) begin
                    check("EPC_Sel", e.cyc, {31'b0, EPC_Sel}, {31'b0, e.sel});
                    check("EPC",     e.cyc, EPC, e.epc);
                end
            end
        end
    end

    initial begin
        // Reset pulse, then free-running sequential fetch.
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, 32'h1111_1111);
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b1, 32'h2222_2222);
        for (int i = 0; i < 4; i++) step($urandom);

        // Jump and jr from a user-mode PC.
        go_jr(32'h0040_0010);
        drive(1'b1, 1'b0, 2'd2, '0, 26'h000_0038, '0, 1'b0, 1'b0, $urandom);
        go_jr(32'h0040_0020);
        drive(1'b1, 1'b0, 2'd1, 32'h0040_0300, '0, '0, 1'b0, 1'b0, $urandom);
        step($urandom);

        // Interrupt from user mode, then held high in kernel mode.
        go_jr(32'h0040_0010);
        drive(1'b1, 1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0, $urandom);

        // Illegal opcode under stall.
        go_jr(32'h0040_0014);
        drive(1'b1, 1'b1, 2'd0, '0, '0, '0, 1'b0, 1'b1, $urandom);
        step($urandom);

        // Stall masks a pending interrupt until it drops.
        go_jr(32'h0040_0100);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'd1, 32'h0000_0040, '0, '0, 1'b1, 1'b0, 32'hABCD_0001);
        drive(1'b1, 1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0, 32'hABCD_0001);
        step($urandom);

        // Reset asserted mid-stall and mid-vectoring.
        go_jr(32'h0040_0200);
        drive(1'b1, 1'b1, 2'd0, '0, '0, '0, 1'b0, 1'b0, $urandom);
        drive(1'b0, 1'b1, 2'd0, '0, '0, '0, 1'b1, 1'b0, $urandom);
        step($urandom);
        step($urandom);

        // Randomized traffic; bias back toward user mode so interrupts get exercised.
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  src;
            logic [31:0] jr;
            src = 2'($urandom_range(0, 3));
            jr  = {1'($urandom_range(0, 3) == 0), 31'($urandom)} & 32'hFFFF_FFFC;
            if (m_pc[31] && $urandom_range(0, 1) == 1) begin
                src = 2'd3;
                jr[31] = 1'b0;
            end
            drive($urandom_range(0, 99) != 0,
                  $urandom_range(0, 4) == 0,
                  src,
                  $urandom & 32'hFFFF_FFFC,
                  26'($urandom),
                  jr,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", cyc, sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h8000_0000, PC loaded on reset (kernel mode, ROM word 0).
REQ-002 SHALL have parameter IRQ_VEC, default 32'h8000_0004, interrupt vector (ROM word 1).
REQ-003 SHALL have parameter EXC_VEC, default 32'h8000_0008, illegal-opcode vector (ROM word 2).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 Stall  in  1  hold PC and IF/ID contents.
REQ-007 PCSrc  in  2  0=PC+4, 1=branch, 2=jump, 3=jr.
REQ-008 BranchTarget  in  32  precomputed branch address.
REQ-009 JumpIndex  in  26  j/jal index field.
REQ-010 JrTarget  in  32  register value for jr/jalr.
REQ-011 Irq  in  1  level-sensitive timer interrupt request.
REQ-012 Illop  in  1  decode flags illegal opcode in ID.
REQ-013 Address  out  32  current PC, drives instruction memory.
REQ-014 Instruction  in  32  word returned by instruction memory, same cycle.
REQ-015 IF_Instr / IF_PC4 / IF_Valid  out  32/32/1  fetched word, its PC+4, valid flag to decode.
REQ-016 EPC_We / EPC_Sel / EPC  out  1/1/32  write strobe, 0=$k0 1=$k1, saved return address.

Function
REQ-017 Kernel mode SHALL be PC[31]; PC+4 SHALL be computed on PC[30:0] and keep PC[31].
REQ-018 Jump SHALL form {PC[31:28], JumpIndex, 2'b00}; branch takes BranchTarget verbatim; jr takes JrTarget verbatim, bit 31 included (only way to leave kernel mode).
REQ-019 Next-PC priority per cycle SHALL be: Illop > (Irq && !PC[31] && !Stall) > Stall > PCSrc.
REQ-020 Illop SHALL load EXC_VEC, pulse EPC_We=1, EPC_Sel=1, EPC=IF_PC4, and flush IF/ID, even when Stall=1.
REQ-021 Accepted Irq SHALL load IRQ_VEC, pulse EPC_We=1, EPC_Sel=0, EPC=current PC, and load IF/ID with a bubble (IF_Instr=0, IF_Valid=0).
REQ-022 Irq SHALL be ignored while PC[31]=1 or Stall=1 and SHALL be re-evaluated each cycle (no latching).
REQ-023 Stall without Illop SHALL hold PC, IF_Instr, IF_PC4 and IF_Valid unchanged.
REQ-024 EPC_We SHALL be high for exactly the cycle the vector is selected; EPC_Sel and EPC are don't-care otherwise.
REQ-025 PCSrc 1..3 with Illop=Irq=0 SHALL update PC next edge; IF/ID flush on redirect is decode's responsibility.

Reset
REQ-026 reset=0 SHALL immediately set PC=RESET_VEC, IF_Instr=0, IF_PC4=0, IF_Valid=0, EPC_We=0, regardless of clk.
REQ-027 Reset asserted mid-stall or mid-vectoring SHALL abandon the operation; first fetch after release is RESET_VEC.

Configuration
REQ-028 With FETCH_IFID_REG_EN defined, IF_Instr/IF_PC4/IF_Valid SHALL be registered (one-cycle latency from Address).
REQ-029 Without FETCH_IFID_REG_EN, IF_Instr=Instruction, IF_PC4=PC+4, IF_Valid=1 combinationally, except IF_Instr=0/IF_Valid=0 in a cycle an Irq or Illop is taken; Stall then holds PC only.

Structure
REQ-030 Vector addresses, PCSrc encodings and the kernel-bit index SHALL live in shared package cpu_pkg.
REQ-031 Next-PC mux SHALL be a sub-module pc_next_mux (combinational); the PC register and IF/ID register stay in fetch_unit.

Verification
REQ-032 Reset pulse -> Address=0x8000_0000, IF_Valid=0; three free-running cycles -> Address 0x8000_0004, 0x8000_0008, 0x8000_000C.
REQ-033 PC=0x0040_0010, PCSrc=2, JumpIndex=0x0000038 -> next Address=0x0000_00E0; PCSrc=3, JrTarget=0x0040_0020 -> Address=0x0040_0020, kernel bit clear.
REQ-034 PC=0x0040_0010, Irq=1 -> next Address=0x8000_0004, EPC_We=1, EPC_Sel=0, EPC=0x0040_0010, IF_Valid=0; Irq held high in kernel -> no further vectoring.
REQ-035 Illop=1 with IF_PC4=0x0040_0018 and Stall=1 -> next Address=0x8000_0008, EPC=0x0040_0018, EPC_Sel=1.
REQ-036 Stall=1 for 3 cycles with Irq=1 in user mode -> Address and IF_* frozen, no EPC_We; Stall drop -> interrupt taken next edge.
